// File: rtl/fb_pixel_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_pixel_writer_if
// Description : Pixel-request handshake plus shared SRAM request bus
//               used by the framebuffer pixel writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_pixel_writer_if;
  // Pixel request side
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_color;

  // Display status and SRAM request side
  logic [1:0]  VGA_state;
  logic        SRAM_busy;
  logic        data_en;
  logic [31:0] data_from_SRAM;
  logic [31:0] SRAM_address;
  logic        read;
  logic        write;
  logic [31:0] data_to_SRAM;
  logic [3:0]  byte_select_out;

  // Status
  logic        oob_err;
  logic [15:0] pix_count;

  // The pixel writer itself
  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color,
    input  VGA_state, SRAM_busy, data_en, data_from_SRAM,
    output pix_ready, SRAM_address, read, write, data_to_SRAM,
    output byte_select_out, oob_err, pix_count
  );

  // The environment: pixel source, SRAM arbiter and VGA timing
  modport master (
    output pix_valid, pix_x, pix_y, pix_color,
    output VGA_state, SRAM_busy, data_en, data_from_SRAM,
    input  pix_ready, SRAM_address, read, write, data_to_SRAM,
    input  byte_select_out, oob_err, pix_count
  );
endinterface
`default_nettype wire

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : fb_pixel_writer
// Description : Single-pixel read-modify-write client of a 1 bpp SRAM
//               framebuffer. Optional macro FB_BLANK_ONLY_EN holds off new
//               SRAM requests while VGA_state indicates active video.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_pixel_writer #(
  parameter logic [31:0] FB_BASE        = 32'h0,
  parameter logic [31:0] WORDS_PER_LINE = 32'd20,
  parameter logic [31:0] FB_WIDTH       = 32'd640,
  parameter logic [31:0] FB_HEIGHT      = 32'd480
) (
  input  logic               clk,
  input  logic               rst,
  fb_pixel_writer_if.slave   bus
);

  localparam logic [1:0] c_VGA_ACTIVE = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_bit;
  logic        r_color;
  logic        r_oob;
  logic [15:0] r_count;

  logic        w_issue_ok;
  logic        w_in_range;
  logic [31:0] w_addr_calc;
  logic [31:0] w_merged;
  logic        w_ready;
  logic        w_read;
  logic        w_write;
  logic        w_rd_done;
  logic        w_wr_done;
  logic        w_accept;

`ifdef FB_BLANK_ONLY_EN
  assign w_issue_ok = !bus.SRAM_busy && (bus.VGA_state != c_VGA_ACTIVE);
`else
  logic w_unused_vga;
  assign w_unused_vga = ^{bus.VGA_state, c_VGA_ACTIVE};
  assign w_issue_ok   = !bus.SRAM_busy;
`endif

  assign w_in_range  = ({22'd0, bus.pix_x} < FB_WIDTH) &&
                       ({23'd0, bus.pix_y} < FB_HEIGHT);
  assign w_addr_calc = FB_BASE
                     + ({23'd0, bus.pix_y} * WORDS_PER_LINE)
                     + {27'd0, bus.pix_x[9:5]};
  assign w_accept    = (r_state == IDLE) && bus.pix_valid;

  // Bit 0 of the word is the leftmost pixel, so x[4:0] indexes directly.
  always_comb begin
    w_merged        = bus.data_from_SRAM;
    w_merged[r_bit] = r_color;
  end

  // Next state and request strobes; a request, once raised, stays up
  // through the *_WAIT state regardless of SRAM_busy or VGA_state.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_read      = 1'b0;
    w_write     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.pix_valid && w_in_range) begin
          w_state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        if (w_issue_ok) begin
          w_read      = 1'b1;
          w_state_nxt = bus.data_en ? WR_REQ : RD_WAIT;
        end
      end
      RD_WAIT: begin
        w_read = 1'b1;
        if (bus.data_en) begin
          w_state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        if (w_issue_ok) begin
          w_write     = 1'b1;
          w_state_nxt = bus.data_en ? IDLE : WR_WAIT;
        end
      end
      WR_WAIT: begin
        w_write = 1'b1;
        if (bus.data_en) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_rd_done = w_read  && bus.data_en;
  assign w_wr_done = w_write && bus.data_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_bit   <= 5'd0;
      r_color <= 1'b0;
      r_oob   <= 1'b0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      // Address is held from latch until the write completes.
      if (w_accept) begin
        if (w_in_range) begin
          r_addr  <= w_addr_calc;
          r_bit   <= bus.pix_x[4:0];
          r_color <= bus.pix_color;
        end else begin
          r_oob   <= 1'b1;
        end
      end
      if (w_rd_done) begin
        r_wdata <= w_merged;
      end
      if (w_wr_done && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign bus.pix_ready       = w_ready;
  assign bus.read            = w_read;
  assign bus.write           = w_write;
  assign bus.SRAM_address    = r_addr;
  assign bus.data_to_SRAM    = r_wdata;
  assign bus.byte_select_out = (w_read || w_write) ? 4'b1111 : 4'b0000;
  assign bus.oob_err         = r_oob;
  assign bus.pix_count       = r_count;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(w_read && w_write));
  a_read_held: assert property (@(posedge clk) disable iff (rst)
    (w_read && !bus.data_en) |=> w_read);
  a_write_held: assert property (@(posedge clk) disable iff (rst)
    (w_write && !bus.data_en) |=> w_write);

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_pixel_writer
// Description : Self-checking bench: vector table plus SRAM responder and
//               write scoreboard, with hand sequences for busy/reset/blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_pixel_writer;

  logic tb_clk = 1'b0;
  logic rst;
  always #5 tb_clk = ~tb_clk;

  fb_pixel_writer_if bus ();

  fb_pixel_writer dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          x;
    int          y;
    logic        color;
    logic [31:0] pre;
    logic [31:0] addr;
    logic [31:0] data;
    bit          oob;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  int          resp_lat = 1;
  bit          sram_en  = 1'b1;
  int          exp_count;
  bit          exp_oob;
  logic [31:0] mem [logic [31:0]];
  exp_t        sbq [$];
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM responder: raises data_en resp_lat cycles after a request is seen
  initial begin : g_sram_model
    int cnt;
    cnt                = 0;
    bus.data_en        = 1'b0;
    bus.data_from_SRAM = 32'd0;
    forever begin
      @(negedge tb_clk);
      if (bus.read || bus.write) begin
        check("rw_exclusive", {31'd0, bus.read && bus.write}, 32'd0);
        check("byte_select", {28'd0, bus.byte_select_out}, 32'hF);
      end
      if (rst || !sram_en) begin
        bus.data_en = 1'b0;
        cnt = 0;
      end else if (bus.data_en) begin
        bus.data_en = 1'b0;
        cnt = 0;
      end else if (bus.read || bus.write) begin
        if (cnt >= resp_lat) begin
          bus.data_en = 1'b1;
          cnt = 0;
          n_done++;
          if (bus.read) begin
            bus.data_from_SRAM = mem.exists(bus.SRAM_address) ? mem[bus.SRAM_address] : 32'd0;
            if (sbq.size() == 0) check("unexpected_read", 32'd1, 32'd0);
            else check("read_addr", bus.SRAM_address, sbq[0].addr);
          end else begin
            mem[bus.SRAM_address] = bus.data_to_SRAM;
            if (sbq.size() == 0) begin
              check("unexpected_write", 32'd1, 32'd0);
            end else begin
              exp_t e;
              e = sbq.pop_front();
              check("write_addr", bus.SRAM_address, e.addr);
              check("write_data", bus.data_to_SRAM, e.data);
            end
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic send_pixel(input int x, input int y, input logic c);
    @(negedge tb_clk);
    bus.pix_valid = 1'b1;
    bus.pix_x     = 10'(x);
    bus.pix_y     = 9'(y);
    bus.pix_color = c;
    @(negedge tb_clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.pix_ready !== 1'b1 && n < 200) begin
      @(negedge tb_clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout got pix_ready=%b expected 1", name, bus.pix_ready);
    end
  endtask

  task automatic expect_pixel(input logic [31:0] addr, input logic [31:0] pre, input logic [31:0] data);
    exp_t e;
    mem[addr] = pre;
    e.addr = addr;
    e.data = data;
    sbq.push_back(e);
    exp_count++;
  endtask

  initial begin : g_main
    bit saw;
    int d0;
    vecs[0] = '{37,  2,   1'b0, 32'hFFFFFFFF, 32'd41,   32'hFFFFFFDF, 1'b0};
    vecs[1] = '{0,   0,   1'b1, 32'h00000000, 32'd0,    32'h00000001, 1'b0};
    vecs[2] = '{639, 479, 1'b1, 32'h00000000, 32'd9599, 32'h80000000, 1'b0};
    vecs[3] = '{640, 0,   1'b1, 32'h0,        32'h0,    32'h0,        1'b1};
    vecs[4] = '{5,   10,  1'b1, 32'h00000000, 32'd200,  32'h00000020, 1'b0};
    vecs[5] = '{0,   480, 1'b1, 32'h0,        32'h0,    32'h0,        1'b1};
    vecs[6] = '{31,  1,   1'b0, 32'hFFFF0000, 32'd20,   32'h7FFF0000, 1'b0};

    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_x = '0;
    bus.pix_y = '0;
    bus.pix_color = 1'b0;
    bus.VGA_state = 2'd0;
    bus.SRAM_busy = 1'b0;
    exp_count = 0;
    exp_oob = 1'b0;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    check("rst_pix_ready", {31'd0, bus.pix_ready}, 32'd1);
    check("rst_read", {31'd0, bus.read}, 32'd0);
    check("rst_write", {31'd0, bus.write}, 32'd0);
    check("rst_addr", bus.SRAM_address, 32'd0);
    check("rst_wdata", bus.data_to_SRAM, 32'd0);
    check("rst_bsel", {28'd0, bus.byte_select_out}, 32'd0);
    check("rst_oob", {31'd0, bus.oob_err}, 32'd0);
    check("rst_count", {16'd0, bus.pix_count}, 32'd0);
    rst = 1'b0;

    // Reset while waiting for read data abandons the pixel
    sram_en = 1'b0;
    send_pixel(3, 3, 1'b1);
    repeat (3) @(negedge tb_clk);
    check("rdwait_read", {31'd0, bus.read}, 32'd1);
    rst = 1'b1;
    @(posedge tb_clk);
    #1;
    check("abort_read", {31'd0, bus.read}, 32'd0);
    check("abort_write", {31'd0, bus.write}, 32'd0);
    check("abort_idle", {31'd0, bus.pix_ready}, 32'd1);
    @(negedge tb_clk);
    rst = 1'b0;
    sram_en = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge tb_clk);
      if (bus.write || bus.read) saw = 1'b1;
    end
    check("abort_no_traffic", {31'd0, saw}, 32'd0);
    check("abort_count", {16'd0, bus.pix_count}, 32'd0);

    // Table-driven pixels
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].oob) exp_oob = 1'b1;
      else expect_pixel(vecs[i].addr, vecs[i].pre, vecs[i].data);
      d0 = n_done;
      send_pixel(vecs[i].x, vecs[i].y, vecs[i].color);
      wait_idle("vec_idle");
      check("vec_count", {16'd0, bus.pix_count}, exp_count);
      check("vec_oob", {31'd0, bus.oob_err}, {31'd0, exp_oob});
      check("vec_sram_ops", n_done - d0, vecs[i].oob ? 32'd0 : 32'd2);
    end

    // SRAM_busy holds off the read; once raised, read is not withdrawn
    resp_lat = 3;
    bus.SRAM_busy = 1'b1;
    expect_pixel(32'd2009, 32'h0, 32'h00001000);
    send_pixel(300, 100, 1'b1);
    saw = 1'b0;
    repeat (10) begin
      if (bus.read) saw = 1'b1;
      @(negedge tb_clk);
    end
    check("busy_no_read", {31'd0, saw}, 32'd0);
    bus.SRAM_busy = 1'b0;
    #1;
    check("busy_fall_read", {31'd0, bus.read}, 32'd1);
    @(negedge tb_clk);
    bus.SRAM_busy = 1'b1;
    #1;
    check("busy_rise_read_held", {31'd0, bus.read}, 32'd1);
    @(negedge tb_clk);
    bus.SRAM_busy = 1'b0;
    wait_idle("busy_idle");
    check("busy_count", {16'd0, bus.pix_count}, exp_count);

    // Completion in the same cycle the request rises
    resp_lat = 0;
    expect_pixel(32'd101, 32'hFFFFFFFF, 32'h7FFFFFFF);
    send_pixel(63, 5, 1'b0);
    wait_idle("fast_idle");
    check("fast_count", {16'd0, bus.pix_count}, exp_count);

    // Active-video window
    resp_lat = 1;
    bus.VGA_state = 2'd2;
    expect_pixel(32'd142, 32'h000000F0, 32'h000000F1);
    send_pixel(64, 7, 1'b1);
`ifdef FB_BLANK_ONLY_EN
    saw = 1'b0;
    repeat (50) begin
      if (bus.read || bus.write) saw = 1'b1;
      @(negedge tb_clk);
    end
    check("vga_no_request", {31'd0, saw}, 32'd0);
    bus.VGA_state = 2'd0;
    #1;
    check("vga_leave_read", {31'd0, bus.read}, 32'd1);
`else
    #1;
    check("vga_ignored_read", {31'd0, bus.read}, 32'd1);
    bus.VGA_state = 2'd0;
`endif
    wait_idle("vga_idle");
    check("vga_count", {16'd0, bus.pix_count}, exp_count);
    check("vga_oob_sticky", {31'd0, bus.oob_err}, 32'd1);

    repeat (3) @(negedge tb_clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
